axi_hp_perf: RTL and testbench
==============================

# axi_hp_perf

Write-bandwidth measurement engine for a Zynq AXI HP slave port. Software programs a base address and transfer length over the internal register bus, then starts the run. The block streams incrementing-pattern write bursts to the HP port as fast as the interconnect accepts them. It counts cycles, beats and responses so software can compute achieved throughput. It sits beside the PS HP port as an internal-bus slave at a `BASEADDR` window.

## Interface
- `BASEADDR`, default 0: word address of register 0; register `n` sits at `BASEADDR+n`.
- `ID_VALUE`, default 32'hA0E1_0001: constant returned by register 0.
- `clk` in 1: single clock for bus, registers and AXI.
- `rst` in 1: asynchronous, active-high reset.
- `bus` intbus_interf slave port: word address, `wr`/`rd` strobes, 32-bit `wdata`/`rdata`. Single-cycle write; read data registered, valid one clock after `rd`.
- `axi_hp` axi_hp_interface master port, write side only:
  - AW: `awaddr[31:0]`, `awlen[3:0]`, `awsize[2:0]`, `awburst[1:0]`, `awvalid`/`awready`.
  - W: `wdata[63:0]`, `wstrb[7:0]`, `wlast`, `wvalid`/`wready`.
  - B: `bresp[1:0]`, `bvalid`/`bready`.
  - AR/R outputs held idle (`arvalid=0`, `rready=1`).

## Operation
Register map, word offsets from `BASEADDR`:
- 0 ID: read-only, returns `ID_VALUE`.
- 1 CTRL:
  - Write bit0=1 starts a run; ignored while busy.
  - Write bit1=1 aborts: returns to IDLE at once, counters frozen.
  - Read: bit0 busy, bit1 done (sticky, cleared by the next start).
- 2 ADDR: base byte address, rw, reset 0. Bits[6:0] forced 0 (128-byte aligned).
- 3 LEN: rw, reset 0.
  - Total beats minus 1; only bits[15:4] are used.
  - Bursts = LEN[15:4]+1; each burst is 16 beats.
- 4 CYCLES: ro, clocks from first `awvalid` to last B handshake inclusive.
- 5 BEATS: ro, accepted W beats.
- 6 BERR: ro, count of B responses with `bresp != 0`.
- Unmapped offsets read 0; writes to them are ignored.

State machine:
- IDLE → RUN on start. Start clears CYCLES/BEATS/BERR and loads the burst and beat counters.
- RUN: AW and W channels proceed independently.
  - AW issues bursts: `awlen=15`, `awsize=3`, `awburst=INCR`, address = ADDR + k·128.
  - W streams beats; data is a 64-bit running beat index starting at 0, `wstrb=8'hFF`, `wlast` on every 16th beat.
  - W may run ahead of AW.
- RUN → WAIT_B when all AW and all W handshakes are done.
- WAIT_B → IDLE when the B count equals the burst count; sets done.
- `bready` is held 1 always. B responses arriving during RUN are counted.
- Abort from any state goes to IDLE with done=0. Outstanding B responses after an abort are ignored.

## Timing
- All outputs reset to 0. Registers, counters and the FSM reset to IDLE with all counts 0.
- Start write at edge N: `awvalid` and `wvalid` are high after edge N+1.
- `awvalid`/`wvalid` hold with stable payload until their ready is sampled high. Back-to-back handshakes occur every cycle when ready stays 1.
- With `awready=wready=1`: the AW handshakes occupy 128 consecutive cycles for LEN=2047. W completes in 2048 consecutive cycles.
- CYCLES saturates at 32'hFFFF_FFFF.
- Bus read of CTRL while a start and a done coincide returns busy=1.
- `rst` mid-run drops `awvalid`/`wvalid` immediately (async).

## Structure
- Shared package `axi_hp_perf_pkg`: register offset constants, CTRL bit positions, the FSM state enum, and the burst-length constant 16.
- One sub-module, `axi_hp_perf_regs`: the bus decode and register file. The top level holds the FSM and the AXI channel counters.

## Test plan
- Reset, read offset 0 → `ID_VALUE`. Read offsets 1–6 → 0.
- Write LEN=2047, CTRL=1, `awready=wready=1`, B replies OKAY 2 cycles after each `wlast` → 128 AW handshakes, addresses 0,128,…,16256. 2048 W beats, 128 `wlast`. BEATS=2048, BERR=0, done=1.
- Same run with `wready` toggling every cycle → still 2048 beats. CYCLES ≈ 2× the full-speed value. Payload is stable while stalled.
- LEN=15, ADDR=0x1000_0040, one B with `bresp=2` → `awaddr=0x1000_0000`, BERR=1, done=1.
- No `bvalid` driven → busy stays 1 in WAIT_B. CTRL=2 → busy=0, done=0.
- Start while busy, and `rst` pulsed mid-run → the second start has no effect. `rst` forces IDLE and all outputs to 0.

Source files
------------

// File: rtl/axi_hp_perf_pkg.sv
// rtl/axi_hp_perf_pkg.sv - shared constants and types for the HP write-bandwidth engine
package axi_hp_perf_pkg;

    localparam logic [2:0] REG_ID     = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_ADDR   = 3'd2;
    localparam logic [2:0] REG_LEN    = 3'd3;
    localparam logic [2:0] REG_CYCLES = 3'd4;
    localparam logic [2:0] REG_BEATS  = 3'd5;
    localparam logic [2:0] REG_BERR   = 3'd6;
    localparam logic [15:0] NUM_REGS  = 16'd7;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_BUSY_BIT  = 0;
    localparam int CTRL_DONE_BIT  = 1;

    localparam int BURST_LEN = 16;
    localparam logic [3:0] AXI_AWLEN      = 4'(BURST_LEN - 1);
    localparam logic [2:0] AXI_AWSIZE     = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_WAIT_B = 2'd2
    } state_e;

endpackage

// File: rtl/axi_hp_perf_regs.sv
// rtl/axi_hp_perf_regs.sv - internal-bus decode and register file
module axi_hp_perf_regs
    import axi_hp_perf_pkg::*;
#(
    parameter int unsigned BASEADDR = 0,
    parameter logic [31:0] ID_VALUE = 32'hA0E1_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        start_pulse,
    output logic        abort_pulse,
    output logic [31:0] base_addr,
    output logic [15:0] len,
    input  logic        busy,
    input  logic        done,
    input  logic [31:0] cycles,
    input  logic [31:0] beats,
    input  logic [31:0] berr
);

    localparam logic [15:0] BASE = 16'(BASEADDR);

    logic [31:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic [31:0] rdata_q, rdata_d;

    logic [15:0] off;
    logic        hit;
    logic        start_eff;
    logic [31:0] ctrl_rd;

    assign off = bus_addr - BASE;
    assign hit = off < NUM_REGS;

    // A start pending this cycle makes the engine busy next cycle; reflect it so a read never sees a stale idle
    assign start_eff = start_q & ~abort_q;

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_BUSY_BIT] = busy | start_eff;
        ctrl_rd[CTRL_DONE_BIT] = done & ~start_eff;
    end

    // Register writes, control pulses and registered read data
    always_comb begin
        addr_d  = addr_q;
        len_d   = len_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        rdata_d = rdata_q;
        if (bus_wr && hit) begin
            case (off[2:0])
                REG_CTRL: begin
                    start_d = bus_wdata[CTRL_START_BIT];
                    abort_d = bus_wdata[CTRL_ABORT_BIT];
                end
                REG_ADDR: addr_d = {bus_wdata[31:7], 7'b0};
                REG_LEN:  len_d  = bus_wdata[15:0];
                default:  ;
            endcase
        end
        if (bus_rd) begin
            rdata_d = '0;
            if (hit) begin
                case (off[2:0])
                    REG_ID:     rdata_d = ID_VALUE;
                    REG_CTRL:   rdata_d = ctrl_rd;
                    REG_ADDR:   rdata_d = addr_q;
                    REG_LEN:    rdata_d = {16'b0, len_q};
                    REG_CYCLES: rdata_d = cycles;
                    REG_BEATS:  rdata_d = beats;
                    REG_BERR:   rdata_d = berr;
                    default:    rdata_d = '0;
                endcase
            end
        end
    end

    // Register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            start_q <= start_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_rdata   = rdata_q;
    assign start_pulse = start_q;
    assign abort_pulse = abort_q;
    assign base_addr   = addr_q;
    assign len         = len_q;

endmodule

// File: rtl/axi_hp_perf.sv
// rtl/axi_hp_perf.sv - AXI HP write-bandwidth engine: FSM, channel counters and statistics
module axi_hp_perf
    import axi_hp_perf_pkg::*;
#(
    parameter int unsigned BASEADDR = 0,
    parameter logic [31:0] ID_VALUE = 32'hA0E1_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [31:0] axi_hp_awaddr,
    output logic [3:0]  axi_hp_awlen,
    output logic [2:0]  axi_hp_awsize,
    output logic [1:0]  axi_hp_awburst,
    output logic        axi_hp_awvalid,
    input  logic        axi_hp_awready,
    output logic [63:0] axi_hp_wdata,
    output logic [7:0]  axi_hp_wstrb,
    output logic        axi_hp_wlast,
    output logic        axi_hp_wvalid,
    input  logic        axi_hp_wready,
    input  logic [1:0]  axi_hp_bresp,
    input  logic        axi_hp_bvalid,
    output logic        axi_hp_bready,
    output logic        axi_hp_arvalid,
    output logic        axi_hp_rready
);

    state_e      state_q, state_d;
    logic [31:0] run_base_q, run_base_d;
    logic [12:0] bursts_q, bursts_d;
    logic [12:0] aw_cnt_q, aw_cnt_d;
    logic [16:0] w_cnt_q, w_cnt_d;
    logic [12:0] b_cnt_q, b_cnt_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] beats_q, beats_d;
    logic [31:0] berr_q, berr_d;
    logic        done_q, done_d;

    logic        start_pulse, abort_pulse;
    logic [31:0] base_addr;
    logic [15:0] len;
    logic        start_go, running;
    logic        aw_all, w_all;
    logic        aw_hs, w_hs, b_hs;
    logic [16:0] total_beats;

    axi_hp_perf_regs #(
        .BASEADDR (BASEADDR),
        .ID_VALUE (ID_VALUE)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .bus_addr    (bus_addr),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .start_pulse (start_pulse),
        .abort_pulse (abort_pulse),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (state_q != ST_IDLE),
        .done        (done_q),
        .cycles      (cycles_q),
        .beats       (beats_q),
        .berr        (berr_q)
    );

    assign total_beats = {bursts_q, 4'b0000};
    assign aw_all      = aw_cnt_q == bursts_q;
    assign w_all       = w_cnt_q == total_beats;
    assign start_go    = start_pulse & ~abort_pulse & (state_q == ST_IDLE);
    assign running     = state_q != ST_IDLE;
    assign aw_hs       = axi_hp_awvalid & axi_hp_awready;
    assign w_hs        = axi_hp_wvalid & axi_hp_wready;
    // bready is tied high, so any bvalid while a run is live is a handshake
    assign b_hs        = axi_hp_bvalid & running;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_go) state_d = ST_RUN;
            ST_RUN: begin
                if (abort_pulse)         state_d = ST_IDLE;
                else if (aw_all && w_all) state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (abort_pulse)              state_d = ST_IDLE;
                else if (b_cnt_d == bursts_q) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: AW/W channels driven straight from held counters, so payload stays stable under stall
    always_comb begin
        axi_hp_awvalid = (state_q == ST_RUN) & ~aw_all;
        axi_hp_wvalid  = (state_q == ST_RUN) & ~w_all;
        axi_hp_awaddr  = axi_hp_awvalid ? run_base_q + 32'({aw_cnt_q, 7'b0}) : '0;
        axi_hp_awlen   = axi_hp_awvalid ? AXI_AWLEN : '0;
        axi_hp_awsize  = axi_hp_awvalid ? AXI_AWSIZE : '0;
        axi_hp_awburst = axi_hp_awvalid ? AXI_BURST_INCR : '0;
        axi_hp_wdata   = axi_hp_wvalid ? 64'(w_cnt_q) : '0;
        axi_hp_wstrb   = axi_hp_wvalid ? 8'hFF : '0;
        axi_hp_wlast   = axi_hp_wvalid & (w_cnt_q[3:0] == 4'hF);
        axi_hp_bready  = 1'b1;
        axi_hp_arvalid = 1'b0;
        axi_hp_rready  = 1'b1;
    end

    // Run counters and statistics; abort freezes them where they stand
    always_comb begin
        run_base_d = run_base_q;
        bursts_d   = bursts_q;
        aw_cnt_d   = aw_cnt_q;
        w_cnt_d    = w_cnt_q;
        b_cnt_d    = b_cnt_q;
        cycles_d   = cycles_q;
        beats_d    = beats_q;
        berr_d     = berr_q;
        done_d     = done_q;
        if (start_go) begin
            run_base_d = base_addr;
            bursts_d   = {1'b0, len[15:4]} + 13'd1;
            aw_cnt_d   = '0;
            w_cnt_d    = '0;
            b_cnt_d    = '0;
            cycles_d   = '0;
            beats_d    = '0;
            berr_d     = '0;
            done_d     = 1'b0;
        end else if (abort_pulse) begin
            done_d = 1'b0;
        end else if (running) begin
            if (aw_hs) aw_cnt_d = aw_cnt_q + 13'd1;
            if (w_hs) begin
                w_cnt_d = w_cnt_q + 17'd1;
                beats_d = beats_q + 32'd1;
            end
            if (b_hs) begin
                b_cnt_d = b_cnt_q + 13'd1;
                if (axi_hp_bresp != 2'b00) berr_d = berr_q + 32'd1;
            end
            if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
            if (state_q == ST_WAIT_B && b_cnt_d == bursts_q) done_d = 1'b1;
        end
    end

    // Counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_base_q <= '0;
            bursts_q   <= '0;
            aw_cnt_q   <= '0;
            w_cnt_q    <= '0;
            b_cnt_q    <= '0;
            cycles_q   <= '0;
            beats_q    <= '0;
            berr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            run_base_q <= run_base_d;
            bursts_q   <= bursts_d;
            aw_cnt_q   <= aw_cnt_d;
            w_cnt_q    <= w_cnt_d;
            b_cnt_q    <= b_cnt_d;
            cycles_q   <= cycles_d;
            beats_q    <= beats_d;
            berr_q     <= berr_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_axi_hp_perf.sv
// tb/tb_axi_hp_perf.sv - randomized self-checking bench for axi_hp_perf
module tb_axi_hp_perf;

    localparam logic [15:0] BASE = 16'h0040;
    localparam logic [31:0] ID   = 32'hA0E1_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_addr = '0;
    logic        bus_wr = 1'b0;
    logic        bus_rd = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready = 1'b0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready, arvalid, rready;

    axi_hp_perf #(.BASEADDR(32'h40), .ID_VALUE(ID)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .axi_hp_awaddr(awaddr), .axi_hp_awlen(awlen), .axi_hp_awsize(awsize),
        .axi_hp_awburst(awburst), .axi_hp_awvalid(awvalid), .axi_hp_awready(awready),
        .axi_hp_wdata(wdata), .axi_hp_wstrb(wstrb), .axi_hp_wlast(wlast),
        .axi_hp_wvalid(wvalid), .axi_hp_wready(wready),
        .axi_hp_bresp(bresp), .axi_hp_bvalid(bvalid), .axi_hp_bready(bready),
        .axi_hp_arvalid(arvalid), .axi_hp_rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // knobs written only by the tests
    int          clear_req = 0;
    int          rdy_mode  = 0;
    bit          b_en      = 1'b1;
    bit          rand_bresp = 1'b0;
    logic [1:0]  bresp_val = 2'b00;
    logic [31:0] exp_base  = '0;

    // observations written only by the slave model
    int          clear_ack = 0;
    int          cyc = 0;
    int          aw_n = 0, w_n = 0, wlast_n = 0, b_n = 0, exp_berr = 0, mon_err = 0;
    int          first_aw = -1, last_aw = 0, last_b = 0;
    logic [31:0] first_awaddr = '0;
    int          b_due[$];
    int          wl_cyc[$];
    int          aw_cyc[$];
    bit          stall_w = 1'b0, stall_aw = 1'b0;
    logic [63:0] stall_wdata = '0;
    logic        stall_wlast = 1'b0;
    logic [31:0] stall_awaddr = '0;

    // AXI slave model: drives readies and B replies, checks every beat against the
    // expected stream (index payload, burst addresses) and records event cycles
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (clear_ack != clear_req) begin
            clear_ack = clear_req;
            aw_n = 0; w_n = 0; wlast_n = 0; b_n = 0; exp_berr = 0; mon_err = 0;
            first_aw = -1; last_aw = 0; last_b = 0;
            b_due.delete(); wl_cyc.delete(); aw_cyc.delete();
            stall_w = 1'b0; stall_aw = 1'b0;
        end
        case (rdy_mode)
            0: begin awready = 1'b1; wready = 1'b1; end
            1: begin awready = 1'b1; wready = cyc[0]; end
            default: begin awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
        endcase
        bvalid = 1'b0;
        bresp  = 2'b00;
        if (b_en && b_due.size() > 0 && b_due[0] <= cyc) begin
            void'(b_due.pop_front());
            bvalid = 1'b1;
            bresp  = rand_bresp ? 2'($urandom_range(0, 3)) : bresp_val;
        end
        if (stall_w && (!wvalid || wdata !== stall_wdata || wlast !== stall_wlast)) mon_err++;
        if (stall_aw && (!awvalid || awaddr !== stall_awaddr)) mon_err++;
        if (awvalid) begin
            if (first_aw < 0) begin
                first_aw = cyc;
                first_awaddr = awaddr;
            end
            if (awready) begin
                if (awaddr !== exp_base + 32'(aw_n * 128) || awlen !== 4'd15 ||
                    awsize !== 3'd3 || awburst !== 2'b01) mon_err++;
                aw_n++;
                last_aw = cyc;
                aw_cyc.push_back(cyc);
            end
        end
        stall_aw = awvalid && !awready;
        stall_awaddr = awaddr;
        if (wvalid && wready) begin
            if (wdata !== 64'(w_n) || wstrb !== 8'hFF || wlast !== ((w_n % 16) == 15)) mon_err++;
            if (wlast) begin
                wlast_n++;
                wl_cyc.push_back(cyc);
            end
            w_n++;
        end
        stall_w = wvalid && !wready;
        stall_wdata = wdata;
        stall_wlast = wlast;
        // a burst's response comes 2 cycles after both its address and last beat are accepted
        while (aw_cyc.size() > 0 && wl_cyc.size() > 0) begin
            int a, w;
            a = aw_cyc.pop_front();
            w = wl_cyc.pop_front();
            b_due.push_back(((a > w) ? a : w) + 2);
        end
        if (bvalid) begin
            b_n++;
            last_b = cyc;
            if (bresp != 2'b00) exp_berr++;
        end
    end

    task automatic bus_write(input int off, input logic [31:0] d);
        @(negedge clk);
        bus_addr = BASE + 16'(off);
        bus_wdata = d;
        bus_wr = 1'b1;
        @(negedge clk);
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input int off, output logic [31:0] d);
        @(negedge clk);
        bus_addr = BASE + 16'(off);
        bus_rd = 1'b1;
        @(negedge clk);
        bus_rd = 1'b0;
        d = bus_rdata;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [31:0] len);
        clear_req++;
        exp_base = {base[31:7], 7'b0};
        bus_write(2, base);
        bus_write(3, len);
        bus_write(1, 32'h1);
    endtask

    task automatic wait_bursts(input string name, input int n, input int limit);
        for (int i = 0; i < limit && b_n < n; i++) @(negedge clk);
        n_checks++;
        if (b_n < n) $display("FAIL %s_timeout: got %0d responses, need %0d", name, b_n, n);
        else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({awvalid, wvalid, wlast, arvalid} !== 4'b0 || awaddr !== 32'd0 || wdata !== 64'd0 || wstrb !== 8'd0)
            $display("FAIL reset_outputs: awv=%b wv=%b awaddr=%h wdata=%h", awvalid, wvalid, awaddr, wdata);
        else n_pass++;
        n_checks++;
        if (bready !== 1'b1 || rready !== 1'b1) $display("FAIL reset_readies: bready=%b rready=%b need 1 1", bready, rready);
        else n_pass++;
        rst = 1'b0;
        bus_read(0, d);
        n_checks++;
        if (d !== ID) $display("FAIL read_id: got %h need %h", d, ID); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            bus_read(k, d);
            n_checks++;
            if (d !== 32'd0) $display("FAIL reset_reg%0d: got %h need 0", k, d); else n_pass++;
        end
    endtask

    task automatic test_full_speed(output int full_cycles);
        logic [31:0] d;
        rdy_mode = 0; b_en = 1'b1; rand_bresp = 1'b0; bresp_val = 2'b00;
        start_run(32'h0, 32'd2047);
        wait_bursts("full", 128, 6000);
        n_checks++;
        if (aw_n != 128 || w_n != 2048 || wlast_n != 128)
            $display("FAIL full_counts: aw=%0d w=%0d wlast=%0d need 128 2048 128", aw_n, w_n, wlast_n);
        else n_pass++;
        n_checks++;
        if (mon_err != 0) $display("FAIL full_stream: %0d bad beats/addresses, need 0", mon_err); else n_pass++;
        n_checks++;
        if (last_aw - first_aw + 1 != 128) $display("FAIL full_aw_span: %0d cycles need 128", last_aw - first_aw + 1);
        else n_pass++;
        bus_read(5, d);
        n_checks++;
        if (d !== 32'd2048) $display("FAIL full_beats: got %0d need 2048", d); else n_pass++;
        bus_read(6, d);
        n_checks++;
        if (d !== 32'd0) $display("FAIL full_berr: got %0d need 0", d); else n_pass++;
        bus_read(4, d);
        full_cycles = int'(d);
        n_checks++;
        if (d !== 32'd2050) $display("FAIL full_cycles: got %0d need 2050", d); else n_pass++;
        bus_read(1, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL full_ctrl: got %h need 2", d); else n_pass++;
    endtask

    task automatic test_wready_toggle(input int full_cycles);
        logic [31:0] d;
        rdy_mode = 1;
        start_run(32'h0, 32'd2047);
        wait_bursts("toggle", 128, 12000);
        n_checks++;
        if (w_n != 2048 || mon_err != 0) $display("FAIL toggle_stream: beats=%0d errs=%0d need 2048 0", w_n, mon_err);
        else n_pass++;
        bus_read(5, d);
        n_checks++;
        if (d !== 32'd2048) $display("FAIL toggle_beats: got %0d need 2048", d); else n_pass++;
        bus_read(4, d);
        n_checks++;
        if (d !== 32'(last_b - first_aw + 1)) $display("FAIL toggle_cycles: got %0d need %0d", d, last_b - first_aw + 1);
        else n_pass++;
        n_checks++;
        if (int'(d) < 2 * full_cycles - 8 || int'(d) > 2 * full_cycles + 8)
            $display("FAIL toggle_ratio: got %0d need about %0d", d, 2 * full_cycles);
        else n_pass++;
    endtask

    task automatic test_len15_berr;
        logic [31:0] d;
        rdy_mode = 0; bresp_val = 2'd2;
        start_run(32'h1000_0040, 32'd15);
        wait_bursts("len15", 1, 200);
        n_checks++;
        if (first_awaddr !== 32'h1000_0000 || aw_n != 1) $display("FAIL len15_awaddr: got %h (%0d bursts) need 10000000 (1)", first_awaddr, aw_n);
        else n_pass++;
        bus_read(2, d);
        n_checks++;
        if (d !== 32'h1000_0000) $display("FAIL len15_addr_reg: got %h need 10000000", d); else n_pass++;
        bus_read(6, d);
        n_checks++;
        if (d !== 32'd1) $display("FAIL len15_berr: got %0d need 1", d); else n_pass++;
        bus_read(1, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL len15_ctrl: got %h need 2", d); else n_pass++;
        bresp_val = 2'd0;
    endtask

    task automatic test_abort;
        logic [31:0] d;
        b_en = 1'b0;
        start_run(32'h0, 32'd15);
        for (int i = 0; i < 100 && w_n < 16; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        bus_read(1, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL wait_b_busy: ctrl %h need 1", d); else n_pass++;
        bus_write(1, 32'h2);
        bus_read(1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL abort_ctrl: ctrl %h need 0", d); else n_pass++;
        b_en = 1'b1;
        repeat (6) @(negedge clk);
        bus_read(1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL abort_late_b: ctrl %h need 0", d); else n_pass++;
    endtask

    task automatic test_random_runs;
        logic [31:0] d, base, len;
        int bursts;
        rdy_mode = 2; rand_bresp = 1'b1;
        for (int r = 0; r < 4; r++) begin
            base = $urandom;
            len = 32'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
            bursts = int'(len >> 4) + 1;
            start_run(base, len);
            wait_bursts("rand", bursts, 3000);
            n_checks++;
            if (aw_n != bursts || w_n != bursts * 16 || mon_err != 0)
                $display("FAIL rand%0d_stream: aw=%0d w=%0d errs=%0d need %0d %0d 0", r, aw_n, w_n, mon_err, bursts, bursts * 16);
            else n_pass++;
            bus_read(6, d);
            n_checks++;
            if (d !== 32'(exp_berr)) $display("FAIL rand%0d_berr: got %0d need %0d", r, d, exp_berr); else n_pass++;
            bus_read(4, d);
            n_checks++;
            if (d !== 32'(last_b - first_aw + 1)) $display("FAIL rand%0d_cycles: got %0d need %0d", r, d, last_b - first_aw + 1);
            else n_pass++;
        end
        rdy_mode = 0; rand_bresp = 1'b0;
    endtask

    task automatic test_busy_start_and_reset;
        logic [31:0] d;
        start_run(32'h0, 32'd2047);
        repeat ($urandom_range(100, 400)) @(negedge clk);
        bus_write(1, 32'h1);
        repeat ($urandom_range(100, 300)) @(negedge clk);
        n_checks++;
        if (mon_err != 0 || aw_n != 128) $display("FAIL restart_ignored: errs=%0d aw=%0d need 0 128", mon_err, aw_n);
        else n_pass++;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0) $display("FAIL async_reset: awv=%b wv=%b need 0 0", awvalid, wvalid);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_ctrl: got %h need 0", d); else n_pass++;
        bus_read(3, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_len: got %h need 0", d); else n_pass++;
    endtask

    initial begin
        int full_cycles;
        test_reset();
        test_full_speed(full_cycles);
        test_wready_toggle(full_cycles);
        test_len15_berr();
        test_abort();
        test_random_runs();
        test_busy_start_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
